// File: rtl/circuito_jogo_pkg.sv
// Shared definitions for the ultimate tic-tac-toe controller: FSM encoding,
// cell codes, 7-segment constants and the winning-line helpers.
package circuito_jogo_pkg;

    // State codes double as the db_estado display value.
    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        PREPARA        = 4'd1,
        ESPERA_MACRO   = 4'd2,
        ESPERA_MICRO   = 4'd4,
        VERIFICA       = 4'd5,
        VERIFICA_MACRO = 4'd6,
        TROCA          = 4'd7,
        FIM            = 4'd8
    } estado_t;

    typedef logic [1:0] celula_t;

    localparam celula_t VAZIO  = 2'd0;
    localparam celula_t J1     = 2'd1;
    localparam celula_t J2     = 2'd2;
    localparam celula_t EMPATE = 2'd3;

    // Index value meaning "no cell selected"; real cells are 1..9.
    localparam logic [3:0] NENHUM = 4'd0;

    // Letter J, active-low gfedcba.
    localparam logic [6:0] SEG_J = 7'b1100001;

    // One 3x3 board: nine 2-bit cells, element i is cell i+1.
    typedef celula_t [8:0] tabuleiro_t;

    // The 8 winning lines as cell masks (bit i = cell i+1).
    function automatic logic [7:0][8:0] linhas_vitoria();
        linhas_vitoria = {9'h054, 9'h111, 9'h124, 9'h092,
                          9'h049, 9'h1C0, 9'h038, 9'h007};
    endfunction

    // True when player j owns every cell of at least one line of t.
    function automatic logic tem_linha(input tabuleiro_t t, input celula_t j);
        logic [8:0]      dono;
        logic [7:0][8:0] l;
        l         = linhas_vitoria();
        tem_linha = 1'b0;
        for (int i = 0; i < 9; i++) dono[i] = (t[i] == j);
        for (int k = 0; k < 8; k++)
            if ((dono & l[k]) == l[k]) tem_linha = 1'b1;
    endfunction

endpackage

// File: rtl/circuito_jogo_hexa7seg.sv
// Decimal digit to active-low 7-segment (gfedcba). Values above 9 blank.
module hexa7seg (
    input  logic [3:0] valor,
    output logic [6:0] seg
);

    // Plain lookup table for digits 0..9.
    always_comb begin
        case (valor)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/circuito_jogo.sv
// Ultimate tic-tac-toe controller: button edge detection, 9x9 board storage,
// macro status, game FSM and debug displays.
module circuito_jogo
    import circuito_jogo_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [8:0] botoes,
    output logic [8:0] leds,
    output logic       pronto,
    output logic       jogar_macro,
    output logic       jogar_micro,
    output logic       db_tem_jogada,
    output logic [6:0] db_macro,
    output logic [6:0] db_micro,
    output logic [6:0] db_estado,
    output logic [6:0] db_jogador,
    output logic [6:0] db_J
);

    estado_t          estado_q, estado_d;
    tabuleiro_t [8:0] tab_q, tab_d;        // tab_q[m] is micro board of macro m+1
    tabuleiro_t       status_q, status_d;  // macro cell status
    logic [3:0]       macro_q, macro_d;
    logic [3:0]       micro_q, micro_d;
    celula_t          jog_q, jog_d;
    logic             tem_q, tem_d;
    logic             tem_ant_q, tem_ant_d;
    logic [8:0]       botoes_q, botoes_d;

    logic             tem, evento, um_quente, valida;
    logic [3:0]       idx, cel;
    tabuleiro_t       micro_atual;
    celula_t          status_bot, micro_bot, status_dest;
    logic             micro_cheio, micro_ganho, macro_cheio, macro_ganho;

    // Press decode, current micro board mux and win/full evaluation.
    always_comb begin
        tem       = |botoes;
        tem_d     = tem;
        tem_ant_d = tem_q;
        botoes_d  = botoes;
        // The event is taken from the registered copy so the button index
        // comes from the same sample that produced the edge.
        evento    = tem_q & ~tem_ant_q;
        um_quente = (botoes_q != '0) && ((botoes_q & (botoes_q - 9'd1)) == '0);
        valida    = evento & um_quente;

        idx = '0;
        for (int i = 0; i < 9; i++)
            if (botoes_q[i]) idx = 4'(i);
        cel = idx + 4'd1;

        micro_atual = '0;
        for (int m = 0; m < 9; m++)
            if (macro_q == 4'(m + 1)) micro_atual = tab_q[m];

        status_bot  = VAZIO;
        micro_bot   = VAZIO;
        // With no last micro the destination counts as closed (free choice).
        status_dest = EMPATE;
        micro_cheio = 1'b1;
        macro_cheio = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (idx == 4'(i)) begin
                status_bot = status_q[i];
                micro_bot  = micro_atual[i];
            end
            if (micro_q == 4'(i + 1)) status_dest = status_q[i];
            if (micro_atual[i] == VAZIO) micro_cheio = 1'b0;
            if (status_q[i] == VAZIO)    macro_cheio = 1'b0;
        end

        micro_ganho = tem_linha(micro_atual, jog_q);
        macro_ganho = tem_linha(status_q, jog_q);
    end

    // State and storage registers; synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            tab_q     <= '0;
            status_q  <= '0;
            macro_q   <= NENHUM;
            micro_q   <= NENHUM;
            jog_q     <= J1;
            tem_q     <= 1'b0;
            tem_ant_q <= 1'b0;
            botoes_q  <= '0;
        end else begin
            estado_q  <= estado_d;
            tab_q     <= tab_d;
            status_q  <= status_d;
            macro_q   <= macro_d;
            micro_q   <= micro_d;
            jog_q     <= jog_d;
            tem_q     <= tem_d;
            tem_ant_q <= tem_ant_d;
            botoes_q  <= botoes_d;
        end
    end

    // Next-state logic of the game FSM.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:        if (iniciar) estado_d = PREPARA;
            PREPARA:        estado_d = ESPERA_MACRO;
            ESPERA_MACRO:   if (valida && status_bot == VAZIO) estado_d = ESPERA_MICRO;
            ESPERA_MICRO:   if (valida && micro_bot == VAZIO)  estado_d = VERIFICA;
            VERIFICA:       estado_d = VERIFICA_MACRO;
            VERIFICA_MACRO: estado_d = (macro_ganho || macro_cheio) ? FIM : TROCA;
            TROCA:          estado_d = (status_dest == VAZIO) ? ESPERA_MICRO : ESPERA_MACRO;
            FIM:            if (iniciar) estado_d = PREPARA;
            default:        estado_d = INICIAL;
        endcase
    end

    // Board, status, index and player updates driven by the current state.
    always_comb begin
        tab_d    = tab_q;
        status_d = status_q;
        macro_d  = macro_q;
        micro_d  = micro_q;
        jog_d    = jog_q;
        case (estado_q)
            PREPARA: begin
                tab_d    = '0;
                status_d = '0;
                macro_d  = NENHUM;
                micro_d  = NENHUM;
                jog_d    = J1;
            end
            ESPERA_MACRO:
                if (valida && status_bot == VAZIO) macro_d = cel;
            ESPERA_MICRO:
                if (valida && micro_bot == VAZIO) begin
                    micro_d = cel;
                    for (int m = 0; m < 9; m++)
                        for (int c = 0; c < 9; c++)
                            if (macro_q == 4'(m + 1) && idx == 4'(c))
                                tab_d[m][c] = jog_q;
                end
            VERIFICA:
                for (int m = 0; m < 9; m++)
                    if (macro_q == 4'(m + 1)) begin
                        if (micro_ganho)      status_d[m] = jog_q;
                        else if (micro_cheio) status_d[m] = EMPATE;
                    end
            TROCA: begin
                jog_d   = (jog_q == J1) ? J2 : J1;
                macro_d = (status_dest == VAZIO) ? micro_q : NENHUM;
            end
            default: ;
        endcase
    end

    // Status outputs and LED content per state.
    always_comb begin
        pronto        = (estado_q == FIM);
        jogar_macro   = (estado_q == ESPERA_MACRO);
        jogar_micro   = (estado_q == ESPERA_MICRO);
        db_tem_jogada = tem;
        db_J          = SEG_J;
        leds          = '0;
        for (int i = 0; i < 9; i++) begin
            case (estado_q)
                ESPERA_MACRO: leds[i] = (status_q[i] == VAZIO);
                ESPERA_MICRO: leds[i] = (micro_atual[i] != VAZIO);
                // A draw never satisfies macro_ganho, so leds stay dark.
                FIM:          leds[i] = macro_ganho && (status_q[i] == jog_q);
                default:      leds[i] = 1'b0;
            endcase
        end
    end

    hexa7seg u_seg_macro   (.valor(macro_q),          .seg(db_macro));
    hexa7seg u_seg_micro   (.valor(micro_q),          .seg(db_micro));
    hexa7seg u_seg_estado  (.valor(estado_q),         .seg(db_estado));
    hexa7seg u_seg_jogador (.valor({2'b00, jog_q}),   .seg(db_jogador));

endmodule

// File: tb/tb_circuito_jogo.sv
// Bench for circuito_jogo: scripted game of 27 presses ending in a player-1
// macro column win, plus reset, restart and mid-game abort sequences.
module tb_circuito_jogo;

    logic       clock = 1'b0;
    logic       reset, iniciar;
    logic [8:0] botoes;
    logic [8:0] leds;
    logic       pronto, jogar_macro, jogar_micro, db_tem_jogada;
    logic [6:0] db_macro, db_micro, db_estado, db_jogador, db_J;

    circuito_jogo dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .leds(leds), .pronto(pronto), .jogar_macro(jogar_macro),
        .jogar_micro(jogar_micro), .db_tem_jogada(db_tem_jogada),
        .db_macro(db_macro), .db_micro(db_micro), .db_estado(db_estado),
        .db_jogador(db_jogador), .db_J(db_J)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] estado;
        logic       jm;
        logic       jmi;
        logic [8:0] leds;
        logic [3:0] macro;
        logic [3:0] micro;
        logic [3:0] jog;
        logic       pronto;
    } exp_t;

    typedef struct {
        logic [8:0] botoes;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Active-low gfedcba digits.
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'h40; 4'd1: seg = 7'h79; 4'd2: seg = 7'h24;
            4'd3: seg = 7'h30; 4'd4: seg = 7'h19; 4'd5: seg = 7'h12;
            4'd6: seg = 7'h02; 4'd7: seg = 7'h78; 4'd8: seg = 7'h00;
            4'd9: seg = 7'h10; default: seg = 7'h7F;
        endcase
    endfunction

    function automatic logic [8:0] b(input int c);
        logic [8:0] v;
        v = 9'd1 << (c - 1);
        return v;
    endfunction

    function automatic exp_t ex(input int es, input int jm, input int jmi,
                                input logic [8:0] l, input int ma, input int mi,
                                input int jg, input int pr);
        exp_t e;
        e.estado = 4'(es); e.jm = 1'(jm); e.jmi = 1'(jmi); e.leds = l;
        e.macro = 4'(ma); e.micro = 4'(mi); e.jog = 4'(jg); e.pronto = 1'(pr);
        return e;
    endfunction

    function automatic vec_t mk(input logic [8:0] bt, input exp_t e);
        vec_t v;
        v.botoes = bt; v.e = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic check_exp(input exp_t e, input string tag);
        chk({tag, ".estado"},  16'(db_estado),   16'(seg(e.estado)));
        chk({tag, ".jmacro"},  16'(jogar_macro), 16'(e.jm));
        chk({tag, ".jmicro"},  16'(jogar_micro), 16'(e.jmi));
        chk({tag, ".leds"},    16'(leds),        16'(e.leds));
        chk({tag, ".macro"},   16'(db_macro),    16'(seg(e.macro)));
        chk({tag, ".micro"},   16'(db_micro),    16'(seg(e.micro)));
        chk({tag, ".jogador"}, 16'(db_jogador),  16'(seg(e.jog)));
        chk({tag, ".pronto"},  16'(pronto),      16'(e.pronto));
    endtask

    // Called at a negedge: press for 4 cycles, release, let the FSM settle.
    task automatic run_vec(input vec_t v, input int n);
        exp_t e;
        botoes = v.botoes;
        sb.push_back(v.e);
        repeat (4) @(negedge clock);
        chk($sformatf("v%0d.tem", n), 16'(db_tem_jogada), 16'd1);
        botoes = '0;
        repeat (8) @(negedge clock);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL v%0d scoreboard empty", n);
        end else begin
            e = sb.pop_front();
            check_exp(e, $sformatf("v%0d", n));
        end
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; botoes = '0;

        // Stimulus table: one press each, expected settled outputs after it.
        vecs.push_back(mk(b(4),       ex(4,0,1,9'h000,4,0,1,0)));  // select macro 4
        vecs.push_back(mk(b(5),       ex(4,0,1,9'h000,5,5,2,0)));  // P1 (4,5)
        vecs.push_back(mk(9'h003,     ex(4,0,1,9'h000,5,5,2,0)));  // two buttons
        vecs.push_back(mk(b(2),       ex(4,0,1,9'h000,2,2,1,0)));  // P2 (5,2)
        vecs.push_back(mk(b(1),       ex(4,0,1,9'h000,1,1,2,0)));  // P1 (2,1)
        vecs.push_back(mk(b(5),       ex(4,0,1,9'h002,5,5,1,0)));  // P2 (1,5)
        vecs.push_back(mk(b(4),       ex(4,0,1,9'h010,4,4,2,0)));  // P1 (5,4)
        vecs.push_back(mk(b(5),       ex(4,0,1,9'h010,4,4,2,0)));  // occupied
        vecs.push_back(mk(b(2),       ex(4,0,1,9'h001,2,2,1,0)));  // P2 (4,2)
        vecs.push_back(mk(b(4),       ex(4,0,1,9'h012,4,4,2,0)));  // P1 (2,4)
        vecs.push_back(mk(b(8),       ex(4,0,1,9'h000,8,8,1,0)));  // P2 (4,8)
        vecs.push_back(mk(b(3),       ex(4,0,1,9'h000,3,3,2,0)));  // P1 (8,3)
        vecs.push_back(mk(b(5),       ex(4,0,1,9'h00A,5,5,1,0)));  // P2 (3,5)
        vecs.push_back(mk(b(5),       ex(4,0,1,9'h01A,5,5,2,0)));  // P1 (5,5)
        vecs.push_back(mk(b(8),       ex(4,0,1,9'h004,8,8,1,0)));  // P2 (5,8)
        vecs.push_back(mk(b(6),       ex(4,0,1,9'h000,6,6,2,0)));  // P1 (8,6)
        vecs.push_back(mk(b(5),       ex(4,0,1,9'h09A,5,5,1,0)));  // P2 (6,5)
        vecs.push_back(mk(b(6),       ex(4,0,1,9'h010,6,6,2,0)));  // P1 wins micro 5
        vecs.push_back(mk(b(2),       ex(4,0,1,9'h009,2,2,1,0)));  // P2 (6,2)
        vecs.push_back(mk(b(5),       ex(2,1,0,9'h1EF,0,5,2,0)));  // into closed 5
        vecs.push_back(mk(b(5),       ex(2,1,0,9'h1EF,0,5,2,0)));  // closed macro
        vecs.push_back(mk(b(9),       ex(4,0,1,9'h000,9,5,2,0)));  // P2 picks 9
        vecs.push_back(mk(b(2),       ex(4,0,1,9'h019,2,2,1,0)));  // P2 (9,2)
        vecs.push_back(mk(b(7),       ex(4,0,1,9'h000,7,7,2,0)));  // P1 wins micro 2
        vecs.push_back(mk(b(8),       ex(4,0,1,9'h024,8,8,1,0)));  // P2 (7,8)
        vecs.push_back(mk(b(9),       ex(8,0,0,9'h092,8,9,1,1)));  // P1 wins game
        vecs.push_back(mk(b(1),       ex(8,0,0,9'h092,8,9,1,1)));  // FIM holds

        // Reset state.
        repeat (2) @(negedge clock);
        check_exp(ex(0,0,0,9'h000,0,0,1,0), "rst");
        chk("dbJ", 16'(db_J), 16'h0061);

        // Start: PREPARA for one cycle, then ESPERA_MACRO; extra iniciar ignored.
        reset = 1'b1; iniciar = 1'b1;
        @(negedge clock);
        chk("ini.s1", 16'(db_estado), 16'(seg(4'd1)));
        @(negedge clock);
        chk("ini.s2", 16'(db_estado), 16'(seg(4'd2)));
        repeat (3) @(negedge clock);
        iniciar = 1'b0;
        check_exp(ex(2,1,0,9'h1FF,0,0,1,0), "ini");

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Restart from FIM clears boards and statuses.
        iniciar = 1'b1;
        @(negedge clock);
        chk("rs.s1", 16'(db_estado), 16'(seg(4'd1)));
        iniciar = 1'b0;
        @(negedge clock);
        check_exp(ex(2,1,0,9'h1FF,0,0,1,0), "restart");
        run_vec(mk(b(3), ex(4,0,1,9'h000,3,0,1,0)), 99);

        // Mid-game reset aborts to INICIAL; stays there without iniciar.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check_exp(ex(0,0,0,9'h000,0,0,1,0), "abort");
        repeat (2) @(negedge clock);
        check_exp(ex(0,0,0,9'h000,0,0,1,0), "idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/circuito_jogo.md
# circuito_jogo

Top-level controller for a two-player "ultimate" tic-tac-toe (jogo da velha): a 3×3 macro board whose cells are each a 3×3 micro board. It takes nine push-buttons, alternates players, enforces the macro/micro selection rules, and detects micro-board and overall wins. It drives cell LEDs and 7-segment debug displays, and sits directly under the board pin wrapper.

## Interface
- No parameters.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous reset, active-low.
- iniciar  in  1  start/restart request; level-sampled.
- botoes  in  9  cell buttons; bit i = cell i+1 (1..9, row-major). Each press is held many cycles.
- leds  out  9  cell LEDs, content depends on state (see Operation).
- pronto  out  1  high while in FIM (game over).
- jogar_macro  out  1  high in ESPERA_MACRO.
- jogar_micro  out  1  high in ESPERA_MICRO.
- db_tem_jogada  out  1  OR of botoes (unregistered).
- db_macro  out  7  7-seg: selected macro cell 1..9, or 0 if none.
- db_micro  out  7  7-seg: last played micro cell 1..9, or 0 if none.
- db_estado  out  7  7-seg: state code.
- db_jogador  out  7  7-seg: current player, 1 or 2.
- db_J  out  7  constant letter "J", 7'b1100001.
- All 7-seg outputs are active-low, ordered gfedcba.

## Operation
- Storage:
  - micro board: 81 cells × 2 bits (0 empty, 1 player 1, 2 player 2).
  - macro status: 9 × 2 bits (0 open, 1/2 won by that player, 3 drawn/full).
  - macro index, last micro index, and current player.
- Button event: tem = |botoes, registered each cycle. A press event is the cycle where tem=1 and the previous tem=0.
  - A press is valid only if botoes is one-hot.
  - A press whose botoes is not one-hot is ignored.
- States and db_estado codes:
  - INICIAL 0 → PREPARA 1 when iniciar=1.
  - PREPARA 1 clears all boards, sets player=1 and indices to none, then goes to ESPERA_MACRO 2.
  - ESPERA_MACRO 2: a valid press on a macro cell with status 0 latches the macro index → ESPERA_MICRO 4. A press on a closed macro cell is ignored.
  - ESPERA_MICRO 4: a valid press on an empty cell of the current macro writes the current player's mark and latches the micro index → VERIFICA 5. A press on an occupied cell is ignored.
  - VERIFICA 5: evaluate the current micro board. Any of the 8 lines all owned by the current player sets macro status to the player; otherwise, if the board is full, status becomes 3. → VERIFICA_MACRO 6.
  - VERIFICA_MACRO 6: the current player owning 3 macro cells in line → FIM 8. Otherwise, all macro statuses ≠0 → FIM 8 (draw). Otherwise → TROCA 7.
  - TROCA 7: toggle player. If macro status at the last micro index is 0, set macro := micro index → ESPERA_MICRO. Otherwise → ESPERA_MACRO (free choice).
  - FIM 8: hold the board. iniciar=1 → PREPARA.
- iniciar is ignored outside INICIAL and FIM.
- leds:
  - ESPERA_MACRO: bit i = macro cell i open.
  - ESPERA_MICRO: bit i = micro cell i of the current macro occupied.
  - FIM: bit i = macro cell i owned by the winner; all 0 on a draw.
  - Otherwise 0.

## Timing
- Reset (reset=0 at a clock edge) forces INICIAL. All storage is cleared; player=1, indices none.
- Reset values: pronto=0, jogar_macro=0, jogar_micro=0, leds=0, db_macro=db_micro="0", db_jogador="1", db_estado="0".
- Reset mid-game aborts immediately with the same values.
- Press-to-state latency: the edge is detected 1 cycle after botoes rises. The state changes on the following edge.
- VERIFICA, VERIFICA_MACRO, TROCA and PREPARA each last 1 cycle, so a played micro reaches the next ESPERA 4 cycles after detection.
- A held button produces exactly one event. A new event needs all buttons released for at least 1 cycle.
- The win check is combinational over the 9 cells of one micro board (selected by a mux) and over the macro statuses.

## Structure
- Shared package: state encoding, cell codes (VAZIO, J1, J2, EMPATE), 7-seg J constant, and a function returning the 8 winning lines.
- Sub-module hexa7seg: 4-bit value to active-low 7-seg, digits 0–9, used for all numeric debug displays.
- Edge detection, boards and FSM live in circuito_jogo.

## Test plan
- reset=0 for 1 cycle, then 1 → pronto=0, jogar_macro=0, db_estado="0", db_jogador="1".
- iniciar=1 for 5 cycles → db_estado passes 1 then 2; jogar_macro=1; leds=9'h1FF.
- botoes=9'b000001000 for 20 cycles → macro 4 selected; jogar_micro=1; db_macro="4"; leds=0.
- botoes=9'b000010000 → cell 5 of macro 4 = J1; db_jogador="2"; jogar_micro=1; db_macro="5" (macro 5 open).
- Pressing two buttons at once, or re-pressing an occupied cell → no state change.
- Player 1 wins micro 5 via 5-row, then a move is directed into macro 5 → jogar_macro=1 and leds bit 4=0. Completing a 3-in-line of macro cells → pronto=1, db_estado="8".
